// File: rtl/pass_mem_arbiter_if.sv
// rtl/pass_mem_arbiter_if.sv - requester and RAM-side signal bundle for pass_mem_arbiter
interface pass_mem_arbiter_if #(
  parameter int AW = 6,
  parameter int DW = 4
);
  logic          req0, req1;
  logic          lock0, lock1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wr;
  logic [DW-1:0] mem_q;

  modport slave (
    input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, mem_q,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_wdata, mem_wr
  );

  modport master (
    output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, mem_q,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_wdata, mem_wr
  );
endinterface

// File: rtl/pass_mem_arbiter.sv
// rtl/pass_mem_arbiter.sv - two-requester arbiter/sequencer for the single-port password RAM
module pass_mem_arbiter #(
  parameter int AW        = 6,
  parameter int DW        = 4,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 8
) (
  input  logic                clk,
  input  logic                rst,
  pass_mem_arbiter_if.slave   bus
);
  localparam int IFW = $clog2(RD_LAT + 2);
  localparam int BW  = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [IFW-1:0] inflight_q, inflight_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [RD_LAT:0] pv_q, pv_d;
  logic [RD_LAT:0] pid_q, pid_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_wr_q, mem_wr_d;

  logic acc0, acc1, acc, acc_we, rd_issue, ret;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    burst_d     = burst_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_d    = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;

    acc0     = bus.req0 && gnt0_q;
    acc1     = bus.req1 && gnt1_q;
    acc      = acc0 || acc1;
    acc_we   = acc0 ? bus.we0 : bus.we1;
    rd_issue = acc && !acc_we;

    if (acc) begin
      mem_addr_d  = acc0 ? bus.addr0 : bus.addr1;
      mem_wdata_d = acc0 ? bus.wdata0 : bus.wdata1;
      mem_wr_d    = acc_we;
      if (burst_q != BW'(MAX_BURST)) burst_d = burst_q + BW'(1);
    end

    // Owner tag rides alongside the read so the word returns to its issuer.
    pv_d  = {pv_q[RD_LAT-1:0], rd_issue};
    pid_d = {pid_q[RD_LAT-1:0], acc1};
    ret   = pv_q[RD_LAT];
    if (ret) begin
      if (pid_q[RD_LAT]) begin
        rvalid1_d = 1'b1;
        rdata1_d  = bus.mem_q;
      end else begin
        rvalid0_d = 1'b1;
        rdata0_d  = bus.mem_q;
      end
    end
    inflight_d = inflight_q + {{(IFW-1){1'b0}}, rd_issue} - {{(IFW-1){1'b0}}, ret};

    case (state_q)
      IDLE: begin
        if (bus.req0 && (!bus.req1 || last_q)) begin
          state_d = OWN0;
          last_d  = 1'b0;
          burst_d = '0;
        end else if (bus.req1) begin
          state_d = OWN1;
          last_d  = 1'b1;
          burst_d = '0;
        end
      end
      OWN0: begin
        if (!bus.lock0 && (!bus.req0 || (bus.req1 && burst_d == BW'(MAX_BURST))))
          state_d = (inflight_d == '0) ? IDLE : DRAIN;
      end
      OWN1: begin
        if (!bus.lock1 && (!bus.req1 || (bus.req0 && burst_d == BW'(MAX_BURST))))
          state_d = (inflight_d == '0) ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (inflight_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    gnt0_d = (state_d == OWN0);
    gnt1_d = (state_d == OWN1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      inflight_q  <= '0;
      burst_q     <= '0;
      pv_q        <= '0;
      pid_q       <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      inflight_q  <= inflight_d;
      burst_q     <= burst_d;
      pv_q        <= pv_d;
      pid_q       <= pid_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wr    = mem_wr_q;
endmodule

// File: tb/tb_pass_mem_arbiter.sv
// tb/tb_pass_mem_arbiter.sv - scoreboard bench for pass_mem_arbiter
module tb_pass_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pass_mem_arbiter_if #(.AW(6), .DW(4)) bus();
  pass_mem_arbiter #(.AW(6), .DW(4), .RD_LAT(2), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic       id;
    logic [3:0] data;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  logic [3:0] ram[64];
  logic [3:0] shadow[64];
  logic [3:0] rd1;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int last_rv_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Write-first RAM, data valid two edges after the address changes.
  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i]    = 4'(i + 13);
      shadow[i] = 4'(i + 13);
    end
    rd1 = '0;
    bus.mem_q = '0;
    forever begin
      @(posedge clk);
      if (bus.mem_wr) ram[bus.mem_addr] <= bus.mem_wdata;
      rd1 <= bus.mem_wr ? bus.mem_wdata : ram[bus.mem_addr];
      bus.mem_q <= rd1;
    end
  end

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  // Monitor and accept tracker: sample at the falling edge.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      chk("gnt_exclusive", int'(bus.gnt0 & bus.gnt1), 0);
      if (bus.rvalid0 || bus.rvalid1) begin
        chk("rv_single", int'(bus.rvalid0 & bus.rvalid1), 0);
        if (q.size() == 0) begin
          chk("rv_unexpected", q.size(), 1);
        end else begin
          e = q.pop_front();
          chk("rv_id", int'(bus.rvalid1), int'(e.id));
          chk("rv_data", int'(e.id ? bus.rdata1 : bus.rdata0), int'(e.data));
          chk("rv_latency", cyc - e.cyc, 3);
        end
        last_rv_cyc = cyc;
      end
      if (bus.req0 && bus.gnt0) begin
        if (bus.we0) shadow[bus.addr0] = bus.wdata0;
        else q.push_back('{id: 1'b0, data: shadow[bus.addr0], cyc: cyc + 1});
      end
      if (bus.req1 && bus.gnt1) begin
        if (bus.we1) shadow[bus.addr1] = bus.wdata1;
        else q.push_back('{id: 1'b1, data: shadow[bus.addr1], cyc: cyc + 1});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 0; bus.req1 = 0; bus.lock0 = 0; bus.lock1 = 0;
    bus.we0 = 0; bus.we1 = 0; bus.addr0 = '0; bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_gnt0"}, int'(bus.gnt0), 0);
    chk({tag, "_gnt1"}, int'(bus.gnt1), 0);
    chk({tag, "_rvalid0"}, int'(bus.rvalid0), 0);
    chk({tag, "_rvalid1"}, int'(bus.rvalid1), 0);
    chk({tag, "_rdata0"}, int'(bus.rdata0), 0);
    chk({tag, "_rdata1"}, int'(bus.rdata1), 0);
    chk({tag, "_mem_addr"}, int'(bus.mem_addr), 0);
    chk({tag, "_mem_wdata"}, int'(bus.mem_wdata), 0);
    chk({tag, "_mem_wr"}, int'(bus.mem_wr), 0);
  endtask

  task automatic wait_rvalid(input bit n);
    for (int i = 0; i < 10 && !(n ? bus.rvalid1 : bus.rvalid0); i++) step();
  endtask

  task automatic drain();
    repeat (10) step();
    chk("drain_queue_empty", q.size(), 0);
  endtask

  initial begin
    int acc;
    int viol;
    int n;
    bit p0, p1;
    int own[$];
    int lens[$];

    idle_inputs();
    rst = 0;
    repeat (3) step();
    check_reset("reset");
    rst = 1;
    step();

    // Single read of 0x08 -> 4'h5
    bus.req0 = 1; bus.addr0 = 6'h08;
    step();
    chk("t1_gnt0_latency", int'(bus.gnt0), 1);
    step();
    acc = cyc;
    chk("t1_mem_addr", int'(bus.mem_addr), 8);
    chk("t1_mem_wr", int'(bus.mem_wr), 0);
    bus.req0 = 0;
    wait_rvalid(0);
    chk("t1_rdata0", int'(bus.rdata0), 5);
    chk("t1_return_edges", cyc - acc, 3);
    step();
    chk("t1_rvalid0_pulse", int'(bus.rvalid0), 0);
    chk("t1_rvalid1_quiet", int'(bus.rvalid1), 0);
    drain();

    // Contention straight out of reset: requester 0 first
    rst = 0;
    repeat (2) step();
    rst = 1;
    bus.req0 = 1; bus.req1 = 1; bus.addr0 = 6'h01; bus.addr1 = 6'h02;
    step();
    chk("t2_gnt0_first", int'(bus.gnt0), 1);
    chk("t2_gnt1_wait", int'(bus.gnt1), 0);
    step();
    step();
    bus.req0 = 0;
    for (int i = 0; i < 30 && !bus.gnt1; i++) step();
    chk("t2_gnt1_rise", int'(bus.gnt1), 1);
    chk("t2_gnt0_low", int'(bus.gnt0), 0);
    chk("t2_gap_after_last_rvalid", cyc - last_rv_cyc, 1);
    bus.req1 = 0;
    drain();

    // Lock hold
    bus.req0 = 1; bus.lock0 = 1;
    step();
    chk("t3_gnt0", int'(bus.gnt0), 1);
    bus.req0 = 0; bus.req1 = 1;
    viol = 0;
    repeat (20) begin
      step();
      if (!bus.gnt0 || bus.gnt1) viol++;
    end
    chk("t3_lock_hold_violations", viol, 0);
    bus.lock0 = 0;
    step();
    chk("t3_release", int'(bus.gnt0), 0);
    step();
    chk("t3_gnt1_after_idle", int'(bus.gnt1), 1);
    bus.req1 = 0;
    drain();

    // Burst limit with both requesting continuously
    rst = 0;
    repeat (2) step();
    rst = 1;
    bus.req0 = 1; bus.req1 = 1;
    p0 = 0; p1 = 0; n = 0;
    for (int k = 0; k < 150; k++) begin
      if (bus.gnt0 && !p0) begin own.push_back(0); n = 0; end
      if (bus.gnt1 && !p1) begin own.push_back(1); n = 0; end
      if ((!bus.gnt0 && p0) || (!bus.gnt1 && p1)) lens.push_back(n);
      if ((bus.gnt0 && bus.req0) || (bus.gnt1 && bus.req1)) n++;
      bus.addr0 = 6'(k);
      bus.addr1 = 6'(k + 32);
      p0 = bus.gnt0;
      p1 = bus.gnt1;
      if (lens.size() == 3) break;
      step();
    end
    bus.req0 = 0; bus.req1 = 0;
    chk("t4_ownerships", lens.size(), 3);
    for (int i = 0; i < lens.size(); i++) chk("t4_burst_len", lens[i], 8);
    for (int i = 0; i < own.size() && i < 3; i++) chk("t4_owner_order", own[i], i % 2);
    drain();

    // Write 4'hA to 0x11 then read it back as requester 1
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 6'h11; bus.wdata1 = 4'hA;
    step();
    chk("t5_gnt1", int'(bus.gnt1), 1);
    step();
    chk("t5_mem_wr", int'(bus.mem_wr), 1);
    chk("t5_mem_addr", int'(bus.mem_addr), 'h11);
    chk("t5_mem_wdata", int'(bus.mem_wdata), 'hA);
    bus.we1 = 0;
    step();
    acc = cyc;
    chk("t5_mem_wr_one_cycle", int'(bus.mem_wr), 0);
    bus.req1 = 0;
    wait_rvalid(1);
    chk("t5_rdata1", int'(bus.rdata1), 'hA);
    chk("t5_return_edges", cyc - acc, 3);
    drain();

    // Reset with two reads in flight
    bus.req0 = 1; bus.addr0 = 6'h03;
    step();
    chk("t6_gnt0", int'(bus.gnt0), 1);
    step();
    bus.addr0 = 6'h04;
    step();
    rst = 0; bus.req0 = 0;
    q.delete();
    step();
    check_reset("t6_reset");
    rst = 1;
    repeat (6) step();
    bus.req0 = 1; bus.addr0 = 6'h08;
    step();
    chk("t6_regrant", int'(bus.gnt0), 1);
    step();
    acc = cyc;
    bus.req0 = 0;
    wait_rvalid(0);
    chk("t6_rdata0", int'(bus.rdata0), 5);
    chk("t6_return_edges", cyc - acc, 3);
    drain();

    chk("final_queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
